// File: rtl/instr_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction fetch, accumulator control and status.
// The master modport is the sequencer side; the slave modport is memory/datapath.
interface instr_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  iRun;
  logic [ADDR_WIDTH-1:0] oPC;
  logic [15:0]           iInstr;
  logic [2:0]            iFlags;
  logic [1:0]            oRpgSelect;
  logic [DATA_WIDTH-1:0] oInm;
  logic [1:0]            oAluOp;
  logic [ADDR_WIDTH-1:0] oDataAddr;
  logic                  oDataWE;
  logic                  oHalted;
  logic                  oIllegal;

  modport master (
    input  iRun, iInstr, iFlags,
    output oPC, oRpgSelect, oInm, oAluOp, oDataAddr, oDataWE, oHalted, oIllegal
  );

  modport slave (
    output iRun, iInstr, iFlags,
    input  oPC, oRpgSelect, oInm, oAluOp, oDataAddr, oDataWE, oHalted, oIllegal
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control unit for the 8-bit accumulator datapath.
// Define INSTR_SEQUENCER_ILLEGAL_TRAP_EN to trap opcodes 12-14 into HALTED with oIllegal set.
module instr_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  instr_sequencer_if.master   bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalted} state_e;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpLdi  = 4'd1;
  localparam logic [3:0] OpLd   = 4'd2;
  localparam logic [3:0] OpSt   = 4'd3;
  localparam logic [3:0] OpAdd  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpAnd  = 4'd6;
  localparam logic [3:0] OpOr   = 4'd7;
  localparam logic [3:0] OpJmp  = 4'd8;
  localparam logic [3:0] OpJz   = 4'd9;
  localparam logic [3:0] OpJc   = 4'd10;
  localparam logic [3:0] OpJn   = 4'd11;
  localparam logic [3:0] OpHalt = 4'd15;

  localparam logic [1:0] SelHold = 2'd0;
  localparam logic [1:0] SelImm  = 2'd1;
  localparam logic [1:0] SelAlu  = 2'd2;
  localparam logic [1:0] SelMem  = 2'd3;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [1:0]            rpg_sel;
  logic                  data_we;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] target;
  logic                  unused_ir;

  assign opcode    = ir_q[15:12];
  assign target    = ir_q[ADDR_WIDTH-1:0];
  assign unused_ir = ^ir_q[11:10];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rpg_sel = SelHold;
    data_we = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (bus.iRun) state_d = StDecode;
      end
      StDecode: begin
        ir_d    = bus.iInstr;
        pc_d    = pc_q + 1'b1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpNop: ;
          OpLdi: rpg_sel = SelImm;
          OpSt:  data_we = 1'b1;
          OpLd, OpAdd, OpSub, OpAnd, OpOr: state_d = StMem;
          OpJmp: pc_d = target;
          OpJz:  if (bus.iFlags[2]) pc_d = target;
          OpJc:  if (bus.iFlags[1]) pc_d = target;
          OpJn:  if (bus.iFlags[0]) pc_d = target;
          OpHalt: state_d = StHalted;
`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
          4'd12, 4'd13, 4'd14: state_d = StHalted;
`endif
          default: ;
        endcase
      end
      StMem: begin
        // The accumulator captures on the clock edge that ends this cycle.
        rpg_sel = (opcode == OpLd) ? SelMem : SelAlu;
        state_d = StFetch;
      end
      StHalted: ;
      default: state_d = StFetch;
    endcase
    // Strobes must be quiet while Reset is held, whatever state the FSM is in.
    if (Reset) begin
      rpg_sel = SelHold;
      data_we = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StFetch;
      pc_q    <= ADDR_WIDTH'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_q == StExec && opcode inside {4'd12, 4'd13, 4'd14}) illegal_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign bus.oIllegal = illegal_q;
`else
  assign bus.oIllegal = 1'b0;
`endif

  assign bus.oPC        = pc_q;
  assign bus.oRpgSelect = rpg_sel;
  assign bus.oInm       = DATA_WIDTH'(ir_q[7:0]);
  assign bus.oAluOp     = ir_q[13:12];
  assign bus.oDataAddr  = target;
  assign bus.oDataWE    = data_we;
  assign bus.oHalted    = (state_q == StHalted);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected strobe events and PC
// changes, an independent monitor pops and compares them as the DUT presents them.
module tb_instr_sequencer;
  localparam int unsigned AW = 10;

`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  instr_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) bus ();

  instr_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(8),
    .RESET_PC  (0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  logic [15:0] rom [1024];
  always @(posedge Clock) bus.iInstr <= rom[bus.oPC];

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  sel;
    logic        we;
    logic [7:0]  inm;
    logic [1:0]  op;
    logic [9:0]  addr;
  } ev_t;

  ev_t         ev_q[$];
  logic [9:0]  pc_exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [9:0]  prev_pc;
  ev_t         ex;
  logic [9:0]  pc_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void fail_unexp(string name, logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endfunction

  function automatic void exp_ev(int c, logic [1:0] s, logic w, logic [7:0] i, logic [1:0] o,
                                 logic [9:0] a);
    ev_t e;
    e.cyc = c; e.sel = s; e.we = w; e.inm = i; e.op = o; e.addr = a;
    ev_q.push_back(e);
  endfunction

  function automatic void exp_pc(logic [9:0] p);
    pc_exp_q.push_back(p);
  endfunction

  // Monitor: cycle count restarts at 1 on the first cycle after Reset drops.
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        cyc = 0;
        prev_pc = bus.oPC;
      end else begin
        cyc++;
        if (bus.oPC !== prev_pc) begin
          if (pc_exp_q.size() == 0) fail_unexp("pc_change", 32'(bus.oPC));
          else begin
            pc_e = pc_exp_q.pop_front();
            check("pc_change", 32'(bus.oPC), 32'(pc_e));
          end
          prev_pc = bus.oPC;
        end
        if (bus.oRpgSelect != 2'd0 || bus.oDataWE) begin
          if (ev_q.size() == 0) fail_unexp("strobe", {29'd0, bus.oDataWE, bus.oRpgSelect});
          else begin
            ex = ev_q.pop_front();
            check("ev_cycle", cyc, ex.cyc);
            check("ev_sel", 32'(bus.oRpgSelect), 32'(ex.sel));
            check("ev_we", 32'(bus.oDataWE), 32'(ex.we));
            if (ex.sel == 2'd1) check("ev_inm", 32'(bus.oInm), 32'(ex.inm));
            else check("ev_addr", 32'(bus.oDataAddr), 32'(ex.addr));
            if (ex.sel == 2'd2) check("ev_aluop", 32'(bus.oAluOp), 32'(ex.op));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
  endtask

  task automatic wait_halt(input int limit);
    int n = 0;
    while (!bus.oHalted && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic       ok;
    logic [9:0] pc0;
    bus.iRun   = 1'b1;
    bus.iFlags = 3'b101;
    bus.iInstr = 16'h0000;
    clear_rom();
    // Program 1: Z=1, C=0, N=1 throughout.
    rom[10'h000] = 16'h1055; rom[10'h001] = 16'h3020; rom[10'h002] = 16'h4020;
    rom[10'h003] = 16'h2030; rom[10'h004] = 16'h7041; rom[10'h005] = 16'h9100;
    rom[10'h100] = 16'h5012; rom[10'h101] = 16'hA200; rom[10'h102] = 16'hB2F0;
    rom[10'h2F0] = 16'h6033; rom[10'h2F1] = 16'hC000; rom[10'h2F2] = 16'h0000;
    rom[10'h2F3] = 16'hF000;
    exp_ev(3,  2'd1, 1'b0, 8'h55, 2'd0, 10'h000);
    exp_ev(6,  2'd0, 1'b1, 8'h00, 2'd0, 10'h020);
    exp_ev(10, 2'd2, 1'b0, 8'h00, 2'd0, 10'h020);
    exp_ev(14, 2'd3, 1'b0, 8'h00, 2'd0, 10'h030);
    exp_ev(18, 2'd2, 1'b0, 8'h00, 2'd3, 10'h041);
    exp_ev(25, 2'd2, 1'b0, 8'h00, 2'd1, 10'h012);
    exp_ev(35, 2'd2, 1'b0, 8'h00, 2'd2, 10'h033);
    for (int p = 1; p <= 6; p++) exp_pc(10'(p));
    exp_pc(10'h100); exp_pc(10'h101); exp_pc(10'h102); exp_pc(10'h103);
    exp_pc(10'h2F0); exp_pc(10'h2F1); exp_pc(10'h2F2);
    if (!TrapEn) begin
      exp_pc(10'h2F3); exp_pc(10'h2F4);
    end

    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    tick();
    check("reset_pc", 32'(bus.oPC), 32'h0);
    check("reset_halted", 32'(bus.oHalted), 32'h0);
    check("reset_illegal", 32'(bus.oIllegal), 32'h0);

    wait_halt(200);
    check("halt_cycle", cyc, TrapEn ? 32'd39 : 32'd45);
    check("illegal_flag", 32'(bus.oIllegal), 32'(TrapEn));
    ok = 1'b1;
    pc0 = bus.oPC;
    repeat (20) begin
      tick();
      if (!bus.oHalted || bus.oPC !== pc0) ok = 1'b0;
    end
    check("halt_hold", 32'(ok), 32'h1);

    // Program 2: JZ not taken, jump to 0x3FF, NOP wraps PC to 0, then stall.
    exp_pc(10'h000);
    @(posedge Clock);
    #1 Reset = 1'b1;
    clear_rom();
    rom[10'h000] = 16'h9100; rom[10'h001] = 16'h83FF; rom[10'h3FF] = 16'h0000;
    bus.iFlags = 3'b000;
    exp_pc(10'h001); exp_pc(10'h002); exp_pc(10'h3FF); exp_pc(10'h000);
    @(posedge Clock);
    #1 Reset = 1'b0;
    tick();
    check("rst_exit_halted", 32'(bus.oHalted), 32'h0);
    check("rst_exit_pc", 32'(bus.oPC), 32'h0);
    check("rst_exit_illegal", 32'(bus.oIllegal), 32'h0);
    repeat (9) @(posedge Clock);
    #1 bus.iRun = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (bus.oPC !== 10'h000 || bus.oRpgSelect != 2'd0 || bus.oDataWE) ok = 1'b0;
    end
    check("stall_hold", 32'(ok), 32'h1);

    // Program 3: LD interrupted by Reset in its MEM cycle, then rerun to HALT.
    @(posedge Clock);
    #1 Reset = 1'b1;
    clear_rom();
    rom[10'h000] = 16'h2030; rom[10'h001] = 16'hF000;
    bus.iRun = 1'b1;
    exp_pc(10'h001); exp_pc(10'h000); exp_pc(10'h001); exp_pc(10'h002);
    exp_ev(4, 2'd3, 1'b0, 8'h00, 2'd0, 10'h030);
    @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    check("rst_mem_sel", 32'(bus.oRpgSelect), 32'h0);
    check("rst_mem_we", 32'(bus.oDataWE), 32'h0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    tick();
    check("rst_mem_pc", 32'(bus.oPC), 32'h0);
    wait_halt(50);
    check("final_halt_cycle", cyc, 32'd8);
    tick();
    check("events_left", ev_q.size(), 32'h0);
    check("pcs_left", pc_exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
